// File: rtl/solve_triangular_seq_pkg.sv
// Shared definitions for the sequential triangular solver:
// FSM state encoding, its debug enum view, and the solve-length helper.
package solve_pkg;

    // Debug view of the controller state.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SOLVE = 2'd1,
        S_DONE  = 2'd2
    } solve_state_t;

    // Same encoding as plain constants for the state register itself.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SOLVE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Solve length in cycles: n(n-1)/2 MAC steps plus n row finishes.
    function automatic int solve_cycles(input int n);
        return (n * (n + 1)) / 2;
    endfunction

endpackage

// File: rtl/solve_triangular_seq_tri_index_gen.sv
// Row/column sequencer for the triangular solver. After a start pulse
// it walks the off-diagonal columns of each row and then that row's
// diagonal, one position per cycle, in back-substitution order (upper)
// or forward-substitution order (lower). It stops after the last diagonal.
module tri_index_gen
    import solve_pkg::*;
#(
    parameter int N = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          lower,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic          is_diag,
    output logic          last
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] ONE      = IW'(1);

    logic lower_q;
    logic active;

    // Current position is the diagonal; the final one ends the walk.
    always_comb begin
        is_diag = (i == j);
        last    = is_diag && (lower_q ? (i == LAST_IDX) : (i == '0));
    end

    // Load the first position on start, then step once per cycle while active.
    always_ff @(posedge clk) begin
        if (rst) begin
            i       <= '0;
            j       <= '0;
            lower_q <= 1'b0;
            active  <= 1'b0;
        end else if (start) begin
            lower_q <= lower;
            active  <= 1'b1;
            if (lower) begin
                i <= '0;
                j <= '0;
            end else begin
                i <= LAST_IDX;
                j <= LAST_IDX;
            end
        end else if (active) begin
            if (is_diag) begin
                if (last) begin
                    active <= 1'b0;
                end else if (lower_q) begin
                    i <= i + ONE;
                    j <= '0;
                end else begin
                    i <= i - ONE;
                    j <= LAST_IDX;
                end
            end else begin
                j <= lower_q ? (j + ONE) : (j - ONE);
            end
        end
    end

endmodule

// File: rtl/solve_triangular_seq.sv
// Sequential triangular-system solver: M*x = b for an N x N upper- or
// lower-triangular real matrix, one multiply-accumulate or one row finish
// per cycle. Handshake: a transfer happens on a rising edge where valid
// and ready are both high; valid, once raised, holds its payload stable
// until the matching ready is seen.
// A zero diagonal yields x[i] = 0.0 and raises the sticky singular flag.
module solve_triangular_seq
    import solve_pkg::*;
#(
    parameter int N = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       lower,
    input  real        M [N][N],
    input  real        b [N],
    output logic       out_valid,
    input  logic       out_ready,
    output real        x [N],
    output logic       singular,
    output logic [1:0] state_dbg
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef real vec_t [N];
    typedef real mat_t [N][N];

    logic [1:0]    state;
    mat_t          m_q;
    vec_t          b_q;
    real           acc;
    logic          accept;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic          at_diag;
    logic          at_last;

    // Handshake flags follow directly from the controller state.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        accept    = in_valid && (state == ST_IDLE);
        state_dbg = state;
    end

    tri_index_gen #(
        .N  (N),
        .IW (IW)
    ) u_index (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .lower   (lower),
        .i       (row),
        .j       (col),
        .is_diag (at_diag),
        .last    (at_last)
    );

    // Controller and datapath: capture job, MAC / row finish, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            acc      <= 0.0;
            singular <= 1'b0;
            for (int r = 0; r < N; r++) begin
                x[r]   <= 0.0;
                b_q[r] <= 0.0;
                for (int c = 0; c < N; c++) begin
                    m_q[r][c] <= 0.0;
                end
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        for (int r = 0; r < N; r++) begin
                            x[r]   <= 0.0;
                            b_q[r] <= b[r];
                            for (int c = 0; c < N; c++) begin
                                m_q[r][c] <= M[r][c];
                            end
                        end
                        acc      <= 0.0;
                        singular <= 1'b0;
                        state    <= ST_SOLVE;
                    end
                end
                ST_SOLVE: begin
                    if (at_diag) begin
                        // Zero pivot: publish 0.0 so later rows see a finite value.
                        if (m_q[row][row] == 0.0) begin
                            x[row]   <= 0.0;
                            singular <= 1'b1;
                        end else begin
                            x[row] <= (b_q[row] - acc) / m_q[row][row];
                        end
                        acc <= 0.0;
                        if (at_last) begin
                            state <= ST_DONE;
                        end
                    end else begin
                        acc <= acc + m_q[row][col] * x[col];
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
